// File: rtl/bus_arbiter.sv
// Two-master, single-slave arbiter for the riscv64 memory-mapped bus.
// Define BUS_ARBITER_RR_EN for round-robin ties; otherwise master 0 wins ties.
`timescale 1ns/1ps
module bus_arbiter #(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_done,
  output logic          m1_done,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] bus_address,
  output logic [DW-1:0] bus_write_data,
  output logic          bus_write_enable,
  output logic          bus_read_enable,
  input  logic [DW-1:0] bus_read_data
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic          r_sel;
  logic          r_we;
  logic          r_m0_gnt;
  logic          r_m1_gnt;
  logic          r_m0_done;
  logic          r_m1_done;
  logic [DW-1:0] r_m0_rdata;
  logic [DW-1:0] r_m1_rdata;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_wen;
  logic          r_ren;

  logic          w_el0;
  logic          w_el1;
  logic          w_win;
  logic          w_grant;
  logic          w_we;

  // A master is blocked in its own done cycle
  assign w_el0   = m0_req & ~r_m0_done;
  assign w_el1   = m1_req & ~r_m1_done;
  assign w_grant = (r_state == IDLE) & (w_el0 | w_el1);
  assign w_we    = w_win ? m1_we : m0_we;

`ifdef BUS_ARBITER_RR_EN
  logic r_last;

  assign w_win = (w_el0 & w_el1) ? ~r_last : w_el1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last <= 1'b1;
    end else if (w_grant) begin
      r_last <= w_win;
    end
  end
`else
  assign w_win = ~w_el0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_grant) w_next = ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel      <= 1'b0;
      r_we       <= 1'b0;
      r_m0_gnt   <= 1'b0;
      r_m1_gnt   <= 1'b0;
      r_m0_done  <= 1'b0;
      r_m1_done  <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wen      <= 1'b0;
      r_ren      <= 1'b0;
    end else begin
      r_m0_done <= 1'b0;
      r_m1_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_sel    <= w_win;
            r_we     <= w_we;
            r_addr   <= w_win ? m1_addr : m0_addr;
            r_wdata  <= w_win ? m1_wdata : m0_wdata;
            r_wen    <= w_we;
            r_ren    <= ~w_we;
            r_m0_gnt <= ~w_win;
            r_m1_gnt <= w_win;
          end
        end
        ACCESS: begin
          r_wen <= 1'b0;
          r_ren <= 1'b0;
        end
        RESP: begin
          if (r_sel) begin
            r_m1_gnt  <= 1'b0;
            r_m1_done <= 1'b1;
            if (!r_we) r_m1_rdata <= bus_read_data;
          end else begin
            r_m0_gnt  <= 1'b0;
            r_m0_done <= 1'b1;
            if (!r_we) r_m0_rdata <= bus_read_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign m0_gnt           = r_m0_gnt;
  assign m1_gnt           = r_m1_gnt;
  assign m0_done          = r_m0_done;
  assign m1_done          = r_m1_done;
  assign m0_rdata         = r_m0_rdata;
  assign m1_rdata         = r_m1_rdata;
  assign bus_address      = r_addr;
  assign bus_write_data   = r_wdata;
  assign bus_write_enable = r_wen;
  assign bus_read_enable  = r_ren;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table, corner sequences,
// random traffic with a per-master read-data scoreboard.
`timescale 1ns/1ps
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [63:0] m0_addr = '0, m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [63:0] m1_addr = '0, m1_wdata = '0;
  logic        m0_gnt, m1_gnt, m0_done, m1_done;
  logic [63:0] m0_rdata, m1_rdata;
  logic [63:0] bus_address, bus_write_data;
  logic        bus_write_enable, bus_read_enable;
  logic [63:0] bus_read_data = '0;

  always #5 clk = ~clk;

  bus_arbiter #(.AW(64), .DW(64)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_done(m0_done), .m1_done(m1_done),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .bus_address(bus_address), .bus_write_data(bus_write_data),
    .bus_write_enable(bus_write_enable), .bus_read_enable(bus_read_enable),
    .bus_read_data(bus_read_data)
  );

  int n_assert = 0;
  int n_fail = 0;
  int n_gnt = 0;
  int n_done = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] last0 = '0;
  logic [63:0] last1 = '0;
  int grant_log[$];
  logic p_g0 = 1'b0, p_g1 = 1'b0;

  typedef struct packed {
    logic        m;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
  } vec_t;

  function automatic logic [63:0] slave_f(input logic [63:0] a);
    if (a == 64'h8000_0010) return 64'h41;
    if (a == 64'h8000_0020) return 64'hDEAD_BEEF;
    return {~a[31:0], a[31:0]} ^ 64'h0F0F_0F0F_0F0F_0F0F;
  endfunction

  // slave: read data valid the cycle after the strobe
  always @(posedge clk) if (bus_read_enable) bus_read_data <= slave_f(bus_address);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("gnt_mutex", {63'd0, m0_gnt & m1_gnt}, 64'd0);
    chk("strobe_mutex", {63'd0, bus_write_enable & bus_read_enable}, 64'd0);
    if (m0_gnt && !p_g0) begin grant_log.push_back(0); n_gnt++; end
    if (m1_gnt && !p_g1) begin grant_log.push_back(1); n_gnt++; end
    p_g0 = m0_gnt;
    p_g1 = m1_gnt;
    if (m0_done) begin
      n_done++;
      if (q0.size() == 0) chk("m0_done_unexpected", 64'd1, 64'd0);
      else chk("m0_rdata", m0_rdata, q0.pop_front());
    end
    if (m1_done) begin
      n_done++;
      if (q1.size() == 0) chk("m1_done_unexpected", 64'd1, 64'd0);
      else chk("m1_rdata", m1_rdata, q1.pop_front());
    end
  end

  task automatic set_req(input bit m, input logic v, input logic we,
                         input logic [63:0] a, input logic [63:0] d);
    if (!m) begin m0_req = v; m0_we = we; m0_addr = a; m0_wdata = d; end
    else    begin m1_req = v; m1_we = we; m1_addr = a; m1_wdata = d; end
  endtask

  task automatic push_exp(input bit m, input logic we, input logic [63:0] a);
    logic [63:0] e;
    if (!m) begin
      e = we ? last0 : slave_f(a);
      last0 = e;
      q0.push_back(e);
    end else begin
      e = we ? last1 : slave_f(a);
      last1 = e;
      q1.push_back(e);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [1:0] oh;
    oh = v.m ? 2'b10 : 2'b01;
    @(negedge clk);
    set_req(v.m, 1'b1, v.we, v.addr, v.wdata);
    if (!v.m) begin q0.push_back(v.exp_rdata); last0 = v.exp_rdata; end
    else      begin q1.push_back(v.exp_rdata); last1 = v.exp_rdata; end
    @(negedge clk);
    chk("wen_T1", {63'd0, bus_write_enable}, {63'd0, v.we});
    chk("ren_T1", {63'd0, bus_read_enable}, {63'd0, ~v.we});
    chk("addr_T1", bus_address, v.addr);
    if (v.we) chk("wdata_T1", bus_write_data, v.wdata);
    chk("gnt_T1", {62'd0, m1_gnt, m0_gnt}, {62'd0, oh});
    @(negedge clk);
    chk("strobe_T2", {62'd0, bus_write_enable, bus_read_enable}, 64'd0);
    chk("gnt_T2", {62'd0, m1_gnt, m0_gnt}, {62'd0, oh});
    @(negedge clk);
    chk("done_T3", {62'd0, m1_done, m0_done}, {62'd0, oh});
    chk("gnt_T3", {62'd0, m1_gnt, m0_gnt}, 64'd0);
    set_req(v.m, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("done_pulse", {62'd0, m1_done, m0_done}, 64'd0);
  endtask

  task automatic rnd_step(input bit m, input bit allow_new);
    logic r, d, we;
    logic [63:0] a;
    r = m ? m1_req : m0_req;
    d = m ? m1_done : m0_done;
    if (r && d) begin
      set_req(m, 1'b0, 1'b0, '0, '0);
    end else if (!r && allow_new && $urandom_range(0, 3) == 0) begin
      we = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      set_req(m, 1'b1, we, a, {$urandom, $urandom});
      push_exp(m, we, a);
    end
  endtask

  initial begin
    vec_t vecs[6];
    int exp_seq[4];
    int k;
    int g_base, d_base;

    vecs[0] = '{1'b0, 1'b0, 64'h8000_0010, 64'h0,    64'h41};
    vecs[1] = '{1'b1, 1'b1, 64'h8000_0000, 64'h41,   64'h0};
    vecs[2] = '{1'b1, 1'b0, 64'h8000_0020, 64'h0,    64'hDEAD_BEEF};
    vecs[3] = '{1'b0, 1'b1, 64'h8000_0008, 64'h1234, 64'h41};
    vecs[4] = '{1'b1, 1'b1, 64'h8000_0018, '1,       64'hDEAD_BEEF};
    vecs[5] = '{1'b0, 1'b0, 64'h8000_0020, 64'h0,    64'hDEAD_BEEF};
    exp_seq = '{0, 1, 0, 1};

    #2 reset = 1'b0;
    #1;
    chk("rst_ctrl", {58'd0, m0_gnt, m1_gnt, m0_done, m1_done,
                     bus_write_enable, bus_read_enable}, 64'd0);
    chk("rst_addr", bus_address, 64'd0);
    chk("rst_rdata", m0_rdata | m1_rdata | bus_write_data, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // both masters held high continuously
    grant_log.delete();
    @(negedge clk);
    push_exp(0, 1'b0, 64'h8000_0010);
    push_exp(0, 1'b0, 64'h8000_0010);
    push_exp(1, 1'b0, 64'h8000_0020);
    push_exp(1, 1'b0, 64'h8000_0020);
    set_req(0, 1'b1, 1'b0, 64'h8000_0010, '0);
    set_req(1, 1'b1, 1'b0, 64'h8000_0020, '0);
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      @(negedge clk);
      if (m0_done || m1_done) k++;
    end
    chk("both_done_count", 64'(k), 64'd4);
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    chk("both_grant_count", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < grant_log.size()) chk("both_grant_seq", 64'(grant_log[i]), 64'(exp_seq[i]));

    // m1 pulses only while m0 is in RESP
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 64'h8000_0020, '0);
    push_exp(0, 1'b0, 64'h8000_0020);
    repeat (2) @(negedge clk);
    set_req(1, 1'b1, 1'b1, 64'h8000_0040, 64'h99);
    @(negedge clk);
    chk("wd_m0_done", {63'd0, m0_done}, 64'd1);
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("wd_idle", {61'd0, bus_write_enable, bus_read_enable, m1_gnt}, 64'd0);
    end

    // reset during ACCESS
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 64'h8000_0030, '0);
    @(negedge clk);
    chk("mid_access_ren", {63'd0, bus_read_enable}, 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_ctrl", {58'd0, m0_gnt, m1_gnt, m0_done, m1_done,
                         bus_write_enable, bus_read_enable}, 64'd0);
    chk("mid_rst_addr", bus_address, 64'd0);
    chk("mid_rst_rdata", m0_rdata | m1_rdata, 64'd0);
    last0 = '0;
    last1 = '0;
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mid_rst_no_done", {62'd0, m1_done, m0_done}, 64'd0);
    end
    run_vec('{1'b0, 1'b0, 64'h8000_0010, 64'h0, 64'h41});

    // random traffic
    g_base = n_gnt;
    d_base = n_done;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      rnd_step(0, 1'b1);
      rnd_step(1, 1'b1);
    end
    for (int c = 0; c < 40 && (m0_req || m1_req); c++) begin
      @(negedge clk);
      rnd_step(0, 1'b0);
      rnd_step(1, 1'b0);
    end
    repeat (2) @(negedge clk);
    chk("rnd_drained", {62'd0, m1_req, m0_req}, 64'd0);
    chk("rnd_q_empty", 64'(q0.size() + q1.size()), 64'd0);
    chk("rnd_gnt_eq_done", 64'(n_gnt - g_base), 64'(n_done - d_base));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
